// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bundle: instruction memory port, redirect request and decode handshake.
interface imem_fetch_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_instr;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_instr;
  logic [31:0]           out_pc;
  logic                  fault;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output fault
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  fault
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: PC, one in-flight synchronous read, 2-entry output FIFO.
// Optional bounds checker enabled by FETCH_BOUNDS_CHECK_EN.
module imem_fetch_ctrl #(
  parameter int unsigned IMEM_DEPTH_WORDS = 1024,
  parameter logic [31:0] RESET_PC         = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  imem_fetch_ctrl_if.master   bus
);
  localparam int unsigned ADDR_WIDTH = $clog2(IMEM_DEPTH_WORDS);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  logic [31:0]  fetch_pc,    fetch_pc_n;
  logic         inflight,    inflight_n;
  logic [31:0]  inflight_pc, inflight_pc_n;
  fetch_entry_t ent0,        ent0_n;
  fetch_entry_t ent1,        ent1_n;
  logic         v0,          v0_n;
  logic         v1,          v1_n;
  logic         fault_q;

  logic         pop;
  logic [1:0]   occ;
  logic         try_issue;
  logic         illegal;
  logic         issue;

  assign bus.imem_addr = fetch_pc[ADDR_WIDTH+1:2];
  assign bus.out_valid = v0;
  assign bus.out_pc    = ent0.pc;
  assign bus.out_instr = ent0.instr;
  assign bus.fault     = fault_q;

`ifdef FETCH_BOUNDS_CHECK_EN
  logic fault_n;
  assign illegal = (fetch_pc[1:0] != 2'b00) ||
                   (32'(fetch_pc[31:2]) >= 32'(IMEM_DEPTH_WORDS));
`else
  assign illegal = 1'b0;
  assign fault_q = 1'b0;
`endif

  // Credit: occupancy after this cycle's pop, counting the read already in flight.
  assign pop       = v0 && bus.out_ready;
  assign occ       = 2'(v0) + 2'(v1) + 2'(inflight) - 2'(pop);
  assign try_issue = !bus.redirect_valid && !fault_q && (occ < 2'd2);
  assign issue     = try_issue && !illegal;

  always_comb begin
    fetch_pc_n    = fetch_pc;
    inflight_n    = 1'b0;
    inflight_pc_n = inflight_pc;
    ent0_n        = ent0;
    ent1_n        = ent1;
    v0_n          = v0;
    v1_n          = v1;
`ifdef FETCH_BOUNDS_CHECK_EN
    fault_n       = fault_q;
`endif

    // Shift FIFO: head always lives in ent0, empty slots are kept zero.
    if (pop) begin
      ent0_n = ent1;
      v0_n   = v1;
      ent1_n = '0;
      v1_n   = 1'b0;
    end

    if (inflight) begin
      if (!v0_n) begin
        ent0_n = '{pc: inflight_pc, instr: bus.imem_instr};
        v0_n   = 1'b1;
      end else begin
        ent1_n = '{pc: inflight_pc, instr: bus.imem_instr};
        v1_n   = 1'b1;
      end
    end

    if (issue) begin
      inflight_n    = 1'b1;
      inflight_pc_n = fetch_pc;
      fetch_pc_n    = fetch_pc + 32'd4;
    end

`ifdef FETCH_BOUNDS_CHECK_EN
    if (try_issue && illegal) fault_n = 1'b1;
`endif

    // Redirect overrides everything except the pop already applied above.
    if (bus.redirect_valid) begin
      ent0_n     = '0;
      ent1_n     = '0;
      v0_n       = 1'b0;
      v1_n       = 1'b0;
      inflight_n = 1'b0;
      fetch_pc_n = bus.redirect_pc;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_n    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      ent0        <= '0;
      ent1        <= '0;
      v0          <= 1'b0;
      v1          <= 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      fetch_pc    <= fetch_pc_n;
      inflight    <= inflight_n;
      inflight_pc <= inflight_pc_n;
      ent0        <= ent0_n;
      ent1        <= ent1_n;
      v0          <= v0_n;
      v1          <= v1_n;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_q     <= fault_n;
`endif
    end
  end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl; memory word n holds 32'h1000_0000 + n.
module tb_imem_fetch_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  imem_fetch_ctrl_if #(.ADDR_WIDTH(10)) bus ();

  imem_fetch_ctrl #(
    .IMEM_DEPTH_WORDS(1024),
    .RESET_PC        (32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory model.
  always @(posedge clk) bus.imem_instr <= 32'h1000_0000 + 32'(bus.imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 after reset release.
  task automatic start(input logic ready);
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = ready;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc);
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_pc"}, bus.out_pc, pc);
    check_eq({tag, "_instr"}, bus.out_instr, 32'h1000_0000 + 32'(pc[11:2]));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;

    // Reset release and streaming
    start(1'b1);
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_pc", bus.out_pc, 32'd0);
    check_eq("rst_instr", bus.out_instr, 32'd0);
    check_eq("rst_fault", 32'(bus.fault), 32'd0);
    check_eq("rst_addr", 32'(bus.imem_addr), 32'd0);
    tick();
    check_eq("c1_valid", 32'(bus.out_valid), 32'd0);
    for (int n = 2; n < 8; n++) begin
      tick();
      check_out("stream", 32'(4 * (n - 2)));
    end

    // Backpressure: hold ready low for 10 cycles of valid output
    start(1'b0);
    tick();
    tick();
    for (int n = 2; n < 12; n++) begin
      check_out("stall", 32'd0);
      tick();
    end
    check_eq("stall_addr", 32'(bus.imem_addr), 32'd2);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_out("release", 32'(4 * k));
      tick();
    end

    // Redirect while streaming
    start(1'b1);
    for (int n = 0; n < 6; n++) tick();
    check_out("pre_redir", 32'h10);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0100;
    tick();
    bus.redirect_valid = 1'b0;
    check_eq("redir_c7_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check_eq("redir_c8_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check_out("redir_c9", 32'h100);
    tick();
    check_out("redir_c10", 32'h104);

    // Redirect with coincident pop, then ready low; then back-to-back redirects
    start(1'b1);
    for (int n = 0; n < 6; n++) tick();
    check_out("pop_redir", 32'h10);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    tick();
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b0;
    check_eq("pr_c7_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check_eq("pr_c8_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check_out("pr_c9", 32'h200);
    tick();
    check_out("pr_c10", 32'h200);
    tick();
    check_out("pr_c11", 32'h200);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0300;
    tick();
    bus.redirect_pc    = 32'h0000_0400;
    check_eq("b2b_c12_valid", 32'(bus.out_valid), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    check_eq("b2b_c13_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check_eq("b2b_c14_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check_out("b2b_c15", 32'h400);

    // Asynchronous reset between edges
    start(1'b1);
    for (int n = 0; n < 5; n++) tick();
    check_out("pre_arst", 32'd12);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("arst_pc", bus.out_pc, 32'd0);
    check_eq("arst_fault", 32'(bus.fault), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check_eq("arst_c1_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check_out("arst_c2", 32'd0);
    tick();
    check_out("arst_c3", 32'd4);

    // Out-of-range redirect target
    start(1'b1);
    for (int n = 0; n < 3; n++) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_1000;
    tick();
    bus.redirect_valid = 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
    tick();
    check_eq("bc_fault_set", 32'(bus.fault), 32'd1);
    tick();
    check_eq("bc_no_issue", 32'(bus.out_valid), 32'd0);
    check_eq("bc_fault_sticky", 32'(bus.fault), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0000;
    tick();
    bus.redirect_valid = 1'b0;
    check_eq("bc_fault_clr", 32'(bus.fault), 32'd0);
    tick();
    tick();
    check_out("bc_resume", 32'd0);
`else
    tick();
    tick();
    check_out("wrap_1000", 32'h0000_1000);
    check_eq("wrap_fault", 32'(bus.fault), 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    check_out("pc_top", 32'hFFFF_FFFC);
    tick();
    check_out("pc_wrap", 32'h0000_0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
